t8254_bus_driver: RTL and testbench
===================================

# t8254_bus_driver

Synchronous bus master that sits directly upstream of the team's 8254 timer model and drives its counter-0 CPU interface (CS_N, A1:A0, D-in, D-out, IOR_N, IOW_N).
- Accepts one high-level command at a time: program counter 0, counter-latch-and-read, or read-back-and-read.
- Expands each command into a sequence of correctly timed byte write/read cycles.
- Returns the read status and count on a one-cycle response pulse.

## Interface
Parameters:
- SETUP_CYC, 1, cycles with CS_N low and address/data stable before the strobe falls (≥1)
- STROBE_CYC, 2, cycles the strobe (IOR_N/IOW_N) is held low (≥1)
- HOLD_CYC, 1, cycles CS_N/address/data are held after the strobe rises (≥1)
- RB_WORD, 8'hC2, read-back command byte (counter 0, latch count and status)

Ports:
- clk  in  1  system clock, all state on rising edge
- rflagreset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE; a command is accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 PROGRAM, 01 LATCH, 10 READBACK, 11 reserved
- cmd_rw  in  2  RW1:RW0 for PROGRAM
- cmd_mode  in  3  M2:M0 for PROGRAM
- cmd_bcd  in  1  BCD bit for PROGRAM
- cmd_count  in  16  initial count for PROGRAM
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  command rejected; valid with rsp_valid
- rsp_status  out  8  status byte (READBACK only, else 0)
- rsp_count  out  16  assembled count (LATCH/READBACK, else 0)
- cs_n  out  1  chip select to timer
- a  out  2  address to timer
- wdata  out  8  write data to timer
- rdata  in  8  read data from timer
- ior_n  out  1  read strobe
- iow_n  out  1  write strobe

## Operation
- Reset values:
  - cs_n=1, ior_n=1, iow_n=1, a=00, wdata=00
  - cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_status=0, rsp_count=0
  - stored rw_q=00
- All fields are captured on acceptance and held until the response.
- PROGRAM:
  - cmd_rw=00: reject. rsp_err=1, no bus access.
  - Otherwise:
    - Write {2'b00,cmd_rw,cmd_mode,cmd_bcd} to a=11.
    - Write count bytes to a=00: rw 01 writes the LSB only, 10 the MSB only, 11 the LSB then the MSB.
    - rw_q←cmd_rw at completion.
- LATCH:
  - rw_q=00: reject.
  - Otherwise write 8'h00 to a=11, then read a=00 per rw_q.
- READBACK:
  - rw_q=00: reject.
  - Otherwise write RB_WORD to a=11, read the status byte from a=00, then read count bytes per rw_q.
- Count assembly: rw 01→{8'h00,lsb}, 10→{msb,8'h00}, 11→{msb,lsb}.
- cmd_op=11: reject.
- Count values are not range- or BCD-checked; validity is the timer's job.
- FSM: IDLE → SETUP → STROBE → HOLD → GAP → (next byte ? SETUP : RESP) → IDLE.
  - Rejection goes IDLE → RESP directly.
  - A byte-step counter (0..3) and the op select the address, data and direction of each access.

## Timing
- Per access: SETUP_CYC cycles (cs_n=0, strobes high) → STROBE_CYC cycles (strobe low) → HOLD_CYC cycles (strobe high, cs_n=0) → 1 GAP cycle (cs_n=1).
  - Defaults give 5 cycles per access.
- Exactly one strobe is low at a time; the strobes are never low with cs_n=1.
- a and wdata change only in the cycle cs_n falls, or in GAP.
- Read data is sampled from rdata at the clock edge that ends the last STROBE cycle.
- Acceptance edge = cycle 0. The first SETUP cycle is cycle 1.
  - rsp_valid rises in the cycle after the last GAP and stays high for exactly 1 cycle.
  - cmd_ready returns high the cycle after rsp_valid.
- Rejection: rsp_valid is high in cycle 1.
- PROGRAM rw=11 at defaults: 3 accesses, rsp_valid in cycle 16.
- cmd_valid while busy is ignored; no queuing.
- rflagreset asserted mid-access:
  - Strobes and cs_n go high immediately and the sequence is aborted with no response.
  - rw_q clears.

## Structure
- Package t8254_pkg:
  - op encodings (OP_PROGRAM, OP_LATCH, OP_READBACK)
  - address constants (ADDR_CNT0=2'b00, ADDR_CTRL=2'b11)
  - latch command 8'h00
  - FSM state enum
- Sub-module t8254_bus_cycle: single-access engine.
  - Inputs: start, is_read, addr, data.
  - Outputs: done, rd_byte, and the bus pins.
  - Owns the SETUP/STROBE/HOLD/GAP counters.
- The top level sequences bytes and assembles the response.

## Test plan
- PROGRAM rw=11, mode=3, bcd=0, count=16'h1234 → writes 8'h36@11, 8'h34@00, 8'h12@00. rsp_valid in cycle 16, rsp_err=0.
- PROGRAM rw=00 → no cs_n activity. rsp_valid in cycle 1 with rsp_err=1.
- After PROGRAM rw=11, LATCH with the bench driving rdata 8'hCD then 8'hAB → write 8'h00@11, two reads @00. rsp_count=16'hABCD.
- After PROGRAM rw=01, READBACK with rdata 8'h96 then 8'h05 → write 8'hC2@11. rsp_status=8'h96, rsp_count=16'h0005.
- LATCH straight out of reset → rsp_err=1. cmd_valid pulses during a busy PROGRAM are ignored (exactly one rsp_valid).
- rflagreset pulse during a STROBE cycle → ior_n/iow_n/cs_n high the same cycle. No rsp_valid. cmd_ready=1 after release.

Source files
------------

// File: rtl/t8254_pkg.sv
// Shared constants and types for the 8254 counter-0 bus driver.
// Op codes, timer addresses, command bytes, FSM states and byte-order helpers.
package t8254_pkg;

   localparam logic [1:0] OP_PROGRAM  = 2'b00;
   localparam logic [1:0] OP_LATCH    = 2'b01;
   localparam logic [1:0] OP_READBACK = 2'b10;

   localparam logic [1:0] ADDR_CNT0 = 2'b00;
   localparam logic [1:0] ADDR_CTRL = 2'b11;

   localparam logic [7:0] LATCH_CMD = 8'h00;

   // Phase of a single bus access
   typedef enum logic [2:0] {
      BUS_IDLE,
      BUS_SETUP,
      BUS_STROBE,
      BUS_HOLD,
      BUS_GAP
   } bus_st_t;

   // Command-level sequencing
   typedef enum logic [1:0] {
      DRV_IDLE,
      DRV_RUN,
      DRV_RESP
   } drv_st_t;

   // Count byte j of a transfer is the MSB for rw=10, or the second byte of rw=11
   function automatic logic byte_is_msb(input logic [1:0] rw, input logic [1:0] j);
      return (rw == 2'b10) || (j == 2'd1);
   endfunction

   // Index of the final access: control write, optional status read, count bytes
   function automatic logic [1:0] last_step(input logic [1:0] op, input logic [1:0] rw);
      logic [1:0] n;
      n = (rw == 2'b11) ? 2'd2 : 2'd1;
      return n + ((op == OP_READBACK) ? 2'd1 : 2'd0);
   endfunction

endpackage

// File: rtl/t8254_bus_cycle.sv
// Single-access engine: one timed read or write cycle on the 8254 CPU bus.
// Ports: start/is_read/addr/data request, done (GAP cycle), rd_byte, bus pins.
module t8254_bus_cycle
   import t8254_pkg::*;
#(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic       clk,
   input  logic       rflagreset,
   input  logic       start,
   input  logic       is_read,
   input  logic [1:0] addr,
   input  logic [7:0] data,
   output logic       done,
   output logic [7:0] rd_byte,
   output logic       cs_n,
   output logic [1:0] a,
   output logic [7:0] wdata,
   input  logic [7:0] rdata,
   output logic       ior_n,
   output logic       iow_n
);

   localparam logic [7:0] SU_LAST = 8'(SETUP_CYC - 1);
   localparam logic [7:0] ST_LAST = 8'(STROBE_CYC - 1);
   localparam logic [7:0] HD_LAST = 8'(HOLD_CYC - 1);

   bus_st_t    st_q, st_d;
   logic [7:0] cnt_q, cnt_d;
   logic       rd_q;
   logic       load;

   // New access may begin from idle or straight out of the gap cycle
   assign load = start && (st_q == BUS_IDLE || st_q == BUS_GAP);

   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      unique case (st_q)
         BUS_IDLE: begin
            if (start) begin
               st_d  = BUS_SETUP;
               cnt_d = 8'd0;
            end
         end
         BUS_SETUP: begin
            if (cnt_q == SU_LAST) begin
               st_d  = BUS_STROBE;
               cnt_d = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         BUS_STROBE: begin
            if (cnt_q == ST_LAST) begin
               st_d  = BUS_HOLD;
               cnt_d = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         BUS_HOLD: begin
            if (cnt_q == HD_LAST) begin
               st_d  = BUS_GAP;
               cnt_d = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         BUS_GAP: begin
            st_d  = start ? BUS_SETUP : BUS_IDLE;
            cnt_d = 8'd0;
         end
         default: begin
            st_d  = BUS_IDLE;
            cnt_d = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rflagreset) begin
      if (rflagreset) begin
         st_q    <= BUS_IDLE;
         cnt_q   <= 8'd0;
         rd_q    <= 1'b0;
         a       <= 2'b00;
         wdata   <= 8'h00;
         rd_byte <= 8'h00;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         if (load) begin
            rd_q  <= is_read;
            a     <= addr;
            wdata <= data;
         end
         if (st_q == BUS_STROBE && cnt_q == ST_LAST && rd_q)
            rd_byte <= rdata;
      end
   end

   // Pins decode from the registered phase so reset forces them high at once
   assign cs_n  = !(st_q == BUS_SETUP || st_q == BUS_STROBE || st_q == BUS_HOLD);
   assign ior_n = !(st_q == BUS_STROBE && rd_q);
   assign iow_n = !(st_q == BUS_STROBE && !rd_q);
   assign done  = (st_q == BUS_GAP);

endmodule

// File: rtl/t8254_bus_driver.sv
// Command sequencer for 8254 counter 0: PROGRAM, LATCH and READBACK to byte cycles.
// Ports: cmd_* request/ready, rsp_* one-cycle response, 8254 CPU bus pins.
module t8254_bus_driver
   import t8254_pkg::*;
#(
   parameter int         SETUP_CYC  = 1,
   parameter int         STROBE_CYC = 2,
   parameter int         HOLD_CYC   = 1,
   parameter logic [7:0] RB_WORD    = 8'hC2
) (
   input  logic        clk,
   input  logic        rflagreset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [1:0]  cmd_rw,
   input  logic [2:0]  cmd_mode,
   input  logic        cmd_bcd,
   input  logic [15:0] cmd_count,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [7:0]  rsp_status,
   output logic [15:0] rsp_count,
   output logic        cs_n,
   output logic [1:0]  a,
   output logic [7:0]  wdata,
   input  logic [7:0]  rdata,
   output logic        ior_n,
   output logic        iow_n
);

   drv_st_t     st_q, st_d;
   logic [1:0]  op_q, rwe_q, rw_q, step_q, cur_j;
   logic [15:0] count_q;
   logic [7:0]  status_q, lsb_q, msb_q, rd_byte, acc_data;
   logic [1:0]  rw_e, acc_addr;
   logic        err_q, accept, reject, last, done, start, acc_rd;

   // PROGRAM carries its own byte order; the others reuse the last programmed one
   assign rw_e   = (cmd_op == OP_PROGRAM) ? cmd_rw : rw_q;
   assign reject = (cmd_op == 2'b11) || (rw_e == 2'b00);
   assign accept = cmd_valid && (st_q == DRV_IDLE);
   assign last   = (step_q == last_step(op_q, rwe_q));
   assign cur_j  = step_q - ((op_q == OP_READBACK) ? 2'd2 : 2'd1);

   always_comb begin
      st_d     = st_q;
      start    = 1'b0;
      acc_rd   = 1'b0;
      acc_addr = ADDR_CTRL;
      acc_data = 8'h00;
      unique case (st_q)
         DRV_IDLE: begin
            if (accept) begin
               if (reject) begin
                  st_d = DRV_RESP;
               end else begin
                  st_d  = DRV_RUN;
                  start = 1'b1;
                  unique case (cmd_op)
                     OP_PROGRAM:  acc_data = {2'b00, cmd_rw, cmd_mode, cmd_bcd};
                     OP_READBACK: acc_data = RB_WORD;
                     default:     acc_data = LATCH_CMD;
                  endcase
               end
            end
         end
         DRV_RUN: begin
            if (done) begin
               if (last) begin
                  st_d = DRV_RESP;
               end else begin
                  start    = 1'b1;
                  acc_addr = ADDR_CNT0;
                  // Next PROGRAM step is count byte number step_q
                  if (op_q == OP_PROGRAM)
                     acc_data = byte_is_msb(rwe_q, step_q) ? count_q[15:8] : count_q[7:0];
                  else
                     acc_rd = 1'b1;
               end
            end
         end
         DRV_RESP: st_d = DRV_IDLE;
         default:  st_d = DRV_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rflagreset) begin
      if (rflagreset) begin
         st_q     <= DRV_IDLE;
         op_q     <= 2'b00;
         rwe_q    <= 2'b00;
         rw_q     <= 2'b00;
         step_q   <= 2'd0;
         count_q  <= 16'h0000;
         err_q    <= 1'b0;
         status_q <= 8'h00;
         lsb_q    <= 8'h00;
         msb_q    <= 8'h00;
      end else begin
         st_q <= st_d;
         if (accept) begin
            op_q     <= cmd_op;
            rwe_q    <= rw_e;
            count_q  <= cmd_count;
            err_q    <= reject;
            step_q   <= 2'd0;
            status_q <= 8'h00;
            lsb_q    <= 8'h00;
            msb_q    <= 8'h00;
         end
         if (st_q == DRV_RUN && done) begin
            if (!last)
               step_q <= step_q + 2'd1;
            if (op_q != OP_PROGRAM && step_q != 2'd0) begin
               if (op_q == OP_READBACK && step_q == 2'd1)
                  status_q <= rd_byte;
               else if (byte_is_msb(rwe_q, cur_j))
                  msb_q <= rd_byte;
               else
                  lsb_q <= rd_byte;
            end
            if (last && op_q == OP_PROGRAM)
               rw_q <= rwe_q;
         end
      end
   end

   assign cmd_ready  = (st_q == DRV_IDLE);
   assign rsp_valid  = (st_q == DRV_RESP);
   assign rsp_err    = rsp_valid && err_q;
   assign rsp_status = rsp_valid ? status_q : 8'h00;
   assign rsp_count  = rsp_valid ? {msb_q, lsb_q} : 16'h0000;

   t8254_bus_cycle #(
      .SETUP_CYC  (SETUP_CYC),
      .STROBE_CYC (STROBE_CYC),
      .HOLD_CYC   (HOLD_CYC)
   ) u_cycle (
      .clk        (clk),
      .rflagreset (rflagreset),
      .start      (start),
      .is_read    (acc_rd),
      .addr       (acc_addr),
      .data       (acc_data),
      .done       (done),
      .rd_byte    (rd_byte),
      .cs_n       (cs_n),
      .a          (a),
      .wdata      (wdata),
      .rdata      (rdata),
      .ior_n      (ior_n),
      .iow_n      (iow_n)
   );

endmodule

// File: tb/tb_t8254_bus_driver.sv
// Scoreboard bench for t8254_bus_driver: expected bus accesses and responses
// are queued at issue time and compared as the DUT produces them.
module tb_t8254_bus_driver;

   logic        clk = 1'b0;
   logic        rflagreset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [1:0]  cmd_rw = 2'b00;
   logic [2:0]  cmd_mode = 3'd0;
   logic        cmd_bcd = 1'b0;
   logic [15:0] cmd_count = 16'h0;
   logic        rsp_valid, rsp_err;
   logic [7:0]  rsp_status;
   logic [15:0] rsp_count;
   logic        cs_n, ior_n, iow_n;
   logic [1:0]  a;
   logic [7:0]  wdata;
   logic [7:0]  rdata = 8'h00;

   always #5 clk = ~clk;

   t8254_bus_driver dut (
      .clk        (clk),
      .rflagreset (rflagreset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_rw     (cmd_rw),
      .cmd_mode   (cmd_mode),
      .cmd_bcd    (cmd_bcd),
      .cmd_count  (cmd_count),
      .rsp_valid  (rsp_valid),
      .rsp_err    (rsp_err),
      .rsp_status (rsp_status),
      .rsp_count  (rsp_count),
      .cs_n       (cs_n),
      .a          (a),
      .wdata      (wdata),
      .rdata      (rdata),
      .ior_n      (ior_n),
      .iow_n      (iow_n)
   );

   typedef struct {
      logic        err;
      logic [7:0]  st;
      logic [15:0] cnt;
      int          cyc;
   } rsp_t;

   typedef struct {
      logic       rd;
      logic [1:0] addr;
      logic [7:0] data;
   } acc_t;

   rsp_t       sb[$];
   acc_t       bq[$];
   logic [7:0] rdq[$];
   rsp_t       e;
   acc_t       cur = '{rd: 1'b0, addr: 2'b00, data: 8'h00};
   int         n_chk = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         acc_cyc = 0;
   logic       cs_p = 1'b1;
   logic       ior_p = 1'b1;
   logic       rsp_p = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Acceptance edge is cycle 0; the cycle after it is cycle 1
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready)
         acc_cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rflagreset) begin
         if (!cs_n && cs_p) begin
            if (bq.size() == 0) begin
               chk("bus_unexp", 32'(cs_n), 32'd1);
            end else begin
               cur = bq.pop_front();
               chk("acc_addr", 32'(a), 32'(cur.addr));
               if (!cur.rd)
                  chk("acc_wdata", 32'(wdata), 32'(cur.data));
            end
         end
         if (!ior_n || !iow_n) begin
            chk("strb_cs", 32'(cs_n), 32'd0);
            chk("strb_dir", 32'({ior_n, iow_n}), cur.rd ? 32'd1 : 32'd2);
         end
         if (!ior_n && ior_p && rdq.size() > 0)
            rdata = rdq.pop_front();
         if (rsp_p)
            chk("ready_after", 32'(cmd_ready), 32'd1);
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               chk("rsp_unexp", 32'(rsp_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
               chk("rsp_status", 32'(rsp_status), 32'(e.st));
               chk("rsp_count", 32'(rsp_count), 32'(e.cnt));
               chk("rsp_cyc", 32'(cyc - acc_cyc + 1), 32'(e.cyc));
            end
         end
      end
      cs_p  = cs_n;
      ior_p = ior_n;
      rsp_p = rsp_valid;
   end

   task automatic push_w(input logic [1:0] ad, input logic [7:0] d);
      bq.push_back('{rd: 1'b0, addr: ad, data: d});
   endtask

   task automatic push_r(input logic [1:0] ad, input logic [7:0] d);
      bq.push_back('{rd: 1'b1, addr: ad, data: 8'h00});
      rdq.push_back(d);
   endtask

   task automatic push_rsp(input logic er, input logic [7:0] s, input logic [15:0] c, input int cy);
      sb.push_back('{err: er, st: s, cnt: c, cyc: cy});
   endtask

   task automatic issue(input logic [1:0] op, input logic [1:0] rw, input logic [2:0] md,
                        input logic bcd, input logic [15:0] cnt);
      int n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      cmd_op    = op;
      cmd_rw    = rw;
      cmd_mode  = md;
      cmd_bcd   = bcd;
      cmd_count = cnt;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_pending"}, 32'(sb.size()), 32'd0);
      chk({tag, "_bus_left"}, 32'(bq.size()), 32'd0);
      sb.delete();
      bq.delete();
      rdq.delete();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_ior_n", 32'(ior_n), 32'd1);
      chk("rst_iow_n", 32'(iow_n), 32'd1);
      chk("rst_a", 32'(a), 32'd0);
      chk("rst_wdata", 32'(wdata), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_status", 32'(rsp_status), 32'd0);
      chk("rst_rsp_count", 32'(rsp_count), 32'd0);
      rflagreset = 1'b0;
      @(negedge clk);

      push_rsp(1'b1, 8'h00, 16'h0000, 1);
      issue(2'b01, 2'b00, 3'd0, 1'b0, 16'h0);
      wait_rsp("latch_from_reset");

      push_w(2'b11, 8'h36);
      push_w(2'b00, 8'h34);
      push_w(2'b00, 8'h12);
      push_rsp(1'b0, 8'h00, 16'h0000, 16);
      issue(2'b00, 2'b11, 3'd3, 1'b0, 16'h1234);
      wait_rsp("prog_rw11");

      push_rsp(1'b1, 8'h00, 16'h0000, 1);
      issue(2'b00, 2'b00, 3'd3, 1'b0, 16'h1234);
      wait_rsp("prog_rw00");

      push_w(2'b11, 8'h00);
      push_r(2'b00, 8'hCD);
      push_r(2'b00, 8'hAB);
      push_rsp(1'b0, 8'h00, 16'hABCD, 16);
      issue(2'b01, 2'b00, 3'd0, 1'b0, 16'h0);
      wait_rsp("latch_rw11");

      push_w(2'b11, 8'h15);
      push_w(2'b00, 8'h07);
      push_rsp(1'b0, 8'h00, 16'h0000, 11);
      issue(2'b00, 2'b01, 3'd2, 1'b1, 16'h0007);
      wait_rsp("prog_rw01");

      push_w(2'b11, 8'hC2);
      push_r(2'b00, 8'h96);
      push_r(2'b00, 8'h05);
      push_rsp(1'b0, 8'h96, 16'h0005, 16);
      issue(2'b10, 2'b00, 3'd0, 1'b0, 16'h0);
      wait_rsp("rb_rw01");

      push_w(2'b11, 8'h20);
      push_w(2'b00, 8'hBE);
      push_rsp(1'b0, 8'h00, 16'h0000, 11);
      issue(2'b00, 2'b10, 3'd0, 1'b0, 16'hBEEF);
      wait_rsp("prog_rw10");

      push_w(2'b11, 8'h00);
      push_r(2'b00, 8'h5A);
      push_rsp(1'b0, 8'h00, 16'h5A00, 11);
      issue(2'b01, 2'b00, 3'd0, 1'b0, 16'h0);
      wait_rsp("latch_rw10");

      push_w(2'b11, 8'hC2);
      push_r(2'b00, 8'hA5);
      push_r(2'b00, 8'h3C);
      push_rsp(1'b0, 8'hA5, 16'h3C00, 16);
      issue(2'b10, 2'b00, 3'd0, 1'b0, 16'h0);
      wait_rsp("rb_rw10");

      push_rsp(1'b1, 8'h00, 16'h0000, 1);
      issue(2'b11, 2'b11, 3'd0, 1'b0, 16'h0);
      wait_rsp("op_reserved");

      push_w(2'b11, 8'h31);
      push_w(2'b00, 8'h02);
      push_w(2'b00, 8'h01);
      push_rsp(1'b0, 8'h00, 16'h0000, 16);
      issue(2'b00, 2'b11, 3'd0, 1'b1, 16'h0102);
      for (int i = 0; i < 8; i++) begin
         cmd_op    = 2'b01;
         cmd_valid = i[0];
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      wait_rsp("busy_ignore");

      push_w(2'b11, 8'h34);
      issue(2'b00, 2'b11, 3'd2, 1'b0, 16'h4321);
      n = 0;
      while (iow_n && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("strobe_seen", 32'(iow_n), 32'd0);
      #2 rflagreset = 1'b1;
      #1;
      chk("abort_cs_n", 32'(cs_n), 32'd1);
      chk("abort_iow_n", 32'(iow_n), 32'd1);
      chk("abort_ior_n", 32'(ior_n), 32'd1);
      bq.delete();
      repeat (2) @(negedge clk);
      rflagreset = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_ready", 32'(cmd_ready), 32'd1);

      push_rsp(1'b1, 8'h00, 16'h0000, 1);
      issue(2'b01, 2'b00, 3'd0, 1'b0, 16'h0);
      wait_rsp("latch_after_abort");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
